clause_bin_unloader: RTL

- Reads back a clause bin one row at a time after solving. The clause bin is an array of NUM_CLAUSES clause1 rows, each with a packed var_value_o and clause_len_o.
- Serialises each row into a valid/ready literal stream for the bin-result writer to the host.
- It is the read-side counterpart of the row write path (wr_i, var_value_i, clause_len_i).

---
 rtl/sat_bin_pkg.sv | 27 ++
 rtl/clause_bin_unloader_if.sv | 26 ++
 rtl/slot_prio_enc.sv | 29 ++
 rtl/clause_bin_unloader.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/sat_bin_pkg.sv
// Shared types for the clause bin: slot encoding, unloader FSM states, slot helpers.
package sat_bin_pkg;

  localparam int unsigned SLOT_W = 3;

  typedef logic [SLOT_W-1:0] slot_t;

  localparam logic [1:0] ABSENT = 2'b00;
  localparam logic [1:0] NEG    = 2'b01;
  localparam logic [1:0] POS    = 2'b10;
  localparam logic [1:0] RSVD   = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWait,
    StScan,
    StNext,
    StDone
  } unload_state_e;

  // Slot layout is {val[1:0], imp}; any non-ABSENT val counts as a literal.
  function automatic logic slot_present(slot_t s);
    return s[2:1] != ABSENT;
  endfunction

endpackage

// File: rtl/clause_bin_unloader_if.sv
// Valid/ready literal stream from the clause bin unloader to the bin-result writer.
interface clause_bin_unloader_if
  import sat_bin_pkg::*;
#(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned VIDX_W = 3
);

  logic              lit_valid;
  logic              lit_ready;
  logic [ADDR_W-1:0] lit_clause;
  logic [VIDX_W-1:0] lit_var;
  slot_t             lit_value;
  logic              lit_last;

  modport master (
    output lit_valid, lit_clause, lit_var, lit_value, lit_last,
    input  lit_ready
  );

  modport slave (
    input  lit_valid, lit_clause, lit_var, lit_value, lit_last,
    output lit_ready
  );

endinterface

// File: rtl/slot_prio_enc.sv
// Lowest-index present slot at or above min_idx_i, plus whether another present slot lies above it.
module slot_prio_enc #(
  parameter int unsigned NUM_VARS = 8,
  parameter int unsigned VIDX_W   = $clog2(NUM_VARS)
) (
  input  logic [NUM_VARS-1:0] present_i,
  input  logic [VIDX_W-1:0]   min_idx_i,
  output logic                found_o,
  output logic [VIDX_W-1:0]   index_o,
  output logic                any_above_o
);

  // Walk downwards so each later hit is lower; an earlier hit means one exists above.
  always_comb begin
    found_o     = 1'b0;
    index_o     = '0;
    any_above_o = 1'b0;
    for (int i = NUM_VARS - 1; i >= 0; i--) begin
      if (present_i[i] && (VIDX_W'(i) >= min_idx_i)) begin
        if (found_o) begin
          any_above_o = 1'b1;
        end
        found_o = 1'b1;
        index_o = VIDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/clause_bin_unloader.sv
// Reads the clause bin row by row after solving and serialises present slots as a literal stream.
module clause_bin_unloader
  import sat_bin_pkg::*;
#(
  parameter int unsigned NUM_VARS    = 8,
  parameter int unsigned NUM_CLAUSES = 8,
  parameter int unsigned ADDR_W      = $clog2(NUM_CLAUSES),
  parameter int unsigned VIDX_W      = $clog2(NUM_VARS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  output logic                       rd_en_o,
  output logic [ADDR_W-1:0]          rd_addr_o,
  input  logic [NUM_VARS*SLOT_W-1:0] rd_var_value_i,
  input  logic [4:0]                 rd_clause_len_i,
  clause_bin_unloader_if.master      lit,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       len_err_o
);

  unload_state_e              state_q, state_d;
  logic [ADDR_W-1:0]          row_q, row_d;
  logic [VIDX_W-1:0]          ptr_q, ptr_d;
  logic [NUM_VARS*SLOT_W-1:0] data_q, data_d;
  logic [4:0]                 len_q, len_d;
  logic [4:0]                 cnt_q, cnt_d;
  logic                       err_q, err_d;

  logic [NUM_VARS-1:0] present;
  logic                found;
  logic [VIDX_W-1:0]   enc_idx;
  logic                any_above;
  slot_t               sel_slot;
  logic                scan_valid;
  logic                handshake;

  always_comb begin
    present = '0;
    for (int k = 0; k < NUM_VARS; k++) begin
      present[k] = slot_present(data_q[k*SLOT_W +: SLOT_W]);
    end
  end

  slot_prio_enc #(
    .NUM_VARS (NUM_VARS),
    .VIDX_W   (VIDX_W)
  ) u_prio_enc (
    .present_i   (present),
    .min_idx_i   (ptr_q),
    .found_o     (found),
    .index_o     (enc_idx),
    .any_above_o (any_above)
  );

  always_comb begin
    sel_slot   = data_q[SLOT_W*enc_idx +: SLOT_W];
    scan_valid = (state_q == StScan) && found;
    handshake  = scan_valid && lit.lit_ready;
  end

  // Stream fields are forced to zero when idle so every output reads 0 out of reset.
  always_comb begin
    lit.lit_valid  = scan_valid;
    lit.lit_clause = scan_valid ? row_q : '0;
    lit.lit_var    = scan_valid ? enc_idx : '0;
    lit.lit_value  = scan_valid ? sel_slot : '0;
    lit.lit_last   = scan_valid && !any_above;
    rd_en_o        = (state_q == StRead);
    rd_addr_o      = (state_q == StRead) ? row_q : '0;
    busy_o         = (state_q != StIdle) && (state_q != StDone);
    done_o         = (state_q == StDone);
    len_err_o      = err_q;
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StRead;
          row_d   = '0;
          err_d   = 1'b0;
        end
      end
      StRead: state_d = StWait;
      StWait: begin
        data_d  = rd_var_value_i;
        len_d   = rd_clause_len_i;
        ptr_d   = '0;
        cnt_d   = '0;
        state_d = (rd_clause_len_i == 5'd0) ? StNext : StScan;
      end
      StScan: begin
        if (!found) begin
          err_d   = 1'b1;
          state_d = StNext;
        end else if (handshake) begin
          cnt_d = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;
          if (any_above) begin
            ptr_d = enc_idx + 1'b1;
          end else begin
            state_d = StNext;
          end
        end
      end
      StNext: begin
        if (cnt_q != len_q) begin
          err_d = 1'b1;
        end
        if (row_q == ADDR_W'(NUM_CLAUSES - 1)) begin
          state_d = StDone;
        end else begin
          row_d   = row_q + 1'b1;
          state_d = StRead;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      row_q   <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule
